// File: rtl/sram_like_bridge.sv
// sram_like_bridge: serialises the core's single-cycle SRAM-style instruction and data
// ports onto one SRAM-like request/response bus. One transaction is outstanding at a time.
// While any request presented this cycle has not completed, stallreq holds the core.
//
// Ports:
//   cpu_clk_50M, cpu_rst_n      clock, asynchronous active-low reset
//   ice, iaddr, inst            fetch request/address, last fetched word
//   dce, daddr, dwe, din, dm    data request/address/byte strobes/store data, last load word
//   flush                       pipeline flush; cancels core requests, drops in-flight result
//   stallreq                    core must hold its requests and not advance
//   req, wr, wstrb, addr, wdata bus request phase (driven from latched fields)
//   addr_ok, data_ok, rdata     bus address accept, completion, read data
module sram_like_bridge #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter bit          DATA_FIRST = 1'b1
) (
    input  logic                cpu_clk_50M,
    input  logic                cpu_rst_n,
    input  logic                ice,
    input  logic [ADDR_W-1:0]   iaddr,
    output logic [DATA_W-1:0]   inst,
    input  logic                dce,
    input  logic [ADDR_W-1:0]   daddr,
    input  logic [DATA_W/8-1:0] dwe,
    input  logic [DATA_W-1:0]   din,
    output logic [DATA_W-1:0]   dm,
    input  logic                flush,
    output logic                stallreq,
    output logic                req,
    output logic                wr,
    output logic [DATA_W/8-1:0] wstrb,
    output logic [ADDR_W-1:0]   addr,
    output logic [DATA_W-1:0]   wdata,
    input  logic                addr_ok,
    input  logic                data_ok,
    input  logic [DATA_W-1:0]   rdata
);

    localparam int unsigned StrbW = DATA_W / 8;

    typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

    state_e             state_q, state_d;
    logic               i_done_q, i_done_d;
    logic               d_done_q, d_done_d;
    logic               discard_q, discard_d;
    logic               sel_d_q, sel_d_d;     // 1: data channel owns the transaction
    logic               wr_q, wr_d;
    logic [StrbW-1:0]   wstrb_q, wstrb_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [DATA_W-1:0]  inst_q, inst_d;
    logic [DATA_W-1:0]  dm_q, dm_d;

    logic pend_i, pend_d, pick_d;

    always_comb begin
        pend_i   = ice & ~i_done_q;
        pend_d   = dce & ~d_done_q;
        pick_d   = pend_d & (DATA_FIRST | ~pend_i);
        stallreq = ~flush & (pend_i | pend_d);

        state_d   = state_q;
        i_done_d  = i_done_q;
        d_done_d  = d_done_q;
        discard_d = discard_q;
        sel_d_d   = sel_d_q;
        wr_d      = wr_q;
        wstrb_d   = wstrb_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        inst_d    = inst_q;
        dm_d      = dm_q;

        unique case (state_q)
            StIdle: begin
                if ((pend_i | pend_d) && !flush) begin
                    state_d = StAddr;
                    sel_d_d = pick_d;
                    if (pick_d) begin
                        addr_d  = daddr;
                        wr_d    = |dwe;
                        wstrb_d = dwe;
                        wdata_d = din;
                    end else begin
                        addr_d  = iaddr;
                        wr_d    = 1'b0;
                        wstrb_d = '0;
                        wdata_d = '0;
                    end
                end
            end
            StAddr: begin
                if (flush) discard_d = 1'b1;
                if (addr_ok) state_d = StData;
            end
            StData: begin
                if (data_ok) begin
                    // A flush arriving together with data_ok also drops the result.
                    if (!discard_q && !flush) begin
                        if (sel_d_q) begin
                            d_done_d = 1'b1;
                            if (!wr_q) dm_d = rdata;
                        end else begin
                            i_done_d = 1'b1;
                            inst_d   = rdata;
                        end
                    end
                    discard_d = 1'b0;
                    state_d   = StIdle;
                end else if (flush) begin
                    discard_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // The core advances in any cycle without a stall, so its next request is new.
        if (flush || !stallreq) begin
            i_done_d = 1'b0;
            d_done_d = 1'b0;
        end
    end

    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state_q   <= StIdle;
            i_done_q  <= 1'b0;
            d_done_q  <= 1'b0;
            discard_q <= 1'b0;
            sel_d_q   <= 1'b0;
            wr_q      <= 1'b0;
            wstrb_q   <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            inst_q    <= '0;
            dm_q      <= '0;
        end else begin
            state_q   <= state_d;
            i_done_q  <= i_done_d;
            d_done_q  <= d_done_d;
            discard_q <= discard_d;
            sel_d_q   <= sel_d_d;
            wr_q      <= wr_d;
            wstrb_q   <= wstrb_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            inst_q    <= inst_d;
            dm_q      <= dm_d;
        end
    end

    assign req   = (state_q == StAddr);
    assign wr    = wr_q;
    assign wstrb = wstrb_q;
    assign addr  = addr_q;
    assign wdata = wdata_q;
    assign inst  = inst_q;
    assign dm    = dm_q;

endmodule

// File: tb/tb_sram_like_bridge.sv
// Testbench for sram_like_bridge: table-driven accesses plus hand-written flush, reset and
// back-to-back sequences. A slave model pops expected bus transactions from a scoreboard
// queue, checks the request fields and answers with the queued read data.
module tb_sram_like_bridge;

    logic        cpu_clk_50M = 1'b0;
    logic        cpu_rst_n;
    logic        ice, dce, flush;
    logic [31:0] iaddr, daddr, din;
    logic [3:0]  dwe;
    logic [31:0] inst, dm;
    logic        stallreq, req, wr;
    logic [3:0]  wstrb;
    logic [31:0] addr, wdata;
    logic        addr_ok, data_ok;
    logic [31:0] rdata;

    sram_like_bridge #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .DATA_FIRST(1'b1)
    ) dut (
        .cpu_clk_50M(cpu_clk_50M),
        .cpu_rst_n  (cpu_rst_n),
        .ice        (ice),
        .iaddr      (iaddr),
        .inst       (inst),
        .dce        (dce),
        .daddr      (daddr),
        .dwe        (dwe),
        .din        (din),
        .dm         (dm),
        .flush      (flush),
        .stallreq   (stallreq),
        .req        (req),
        .wr         (wr),
        .wstrb      (wstrb),
        .addr       (addr),
        .wdata      (wdata),
        .addr_ok    (addr_ok),
        .data_ok    (data_ok),
        .rdata      (rdata)
    );

    always #5 cpu_clk_50M = ~cpu_clk_50M;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } bus_t;

    typedef struct {
        logic        ice;
        logic [31:0] iaddr;
        logic        dce;
        logic [31:0] daddr;
        logic [3:0]  dwe;
        logic [31:0] din;
        logic [31:0] rd_i;
        logic [31:0] rd_d;
        int          aw;
        int          dw;
        int          cycles;
        logic [31:0] exp_inst;
        logic [31:0] exp_dm;
    } vec_t;

    bus_t sb[$];
    vec_t vecs[5];
    int   aw_wait, dw_wait;
    int   n_tests, n_fail;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge cpu_clk_50M);
        #1;
    endtask

    // Called at the sample point of cycle 0; returns the cycle in which stallreq is low.
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (stallreq === 1'b1 && cyc < 200) begin
            step();
            #2;
            cyc++;
        end
        if (stallreq !== 1'b0) begin
            n_tests++;
            n_fail++;
            $display("FAIL stall_timeout: stallreq=%b after %0d cycles", stallreq, cyc);
        end
    endtask

    task automatic push_fetch(input logic [31:0] a, input logic [31:0] rd);
        bus_t t;
        t = '{a, 1'b0, 4'h0, 32'h0, rd};
        sb.push_back(t);
    endtask

    task automatic push_data(input logic [31:0] a, input logic [3:0] we, input logic [31:0] wd,
                             input logic [31:0] rd);
        bus_t t;
        t = '{a, |we, we, wd, rd};
        sb.push_back(t);
    endtask

    // Slave model: acts at 1 time unit after each rising edge.
    bus_t s_cur;
    int   s_phase, s_cnt;
    bit   s_have;

    initial begin
        addr_ok = 1'b0;
        data_ok = 1'b0;
        rdata   = '0;
        s_phase = 0;
        s_cnt   = 0;
        s_have  = 1'b0;
        forever begin
            @(posedge cpu_clk_50M);
            #1;
            addr_ok = 1'b0;
            data_ok = 1'b0;
            if (!cpu_rst_n) begin
                s_phase = 0;
                s_cnt   = 0;
                s_have  = 1'b0;
            end else if (s_phase == 0) begin
                if (req) begin
                    if (!s_have) begin
                        if (sb.size() == 0) begin
                            n_tests++;
                            n_fail++;
                            $display("FAIL unexpected_req: addr=%h with empty scoreboard", addr);
                        end else begin
                            s_cur  = sb.pop_front();
                            s_have = 1'b1;
                        end
                    end
                    if (s_have) begin
                        check("bus_addr", addr, s_cur.addr);
                        check("bus_wr", {31'h0, wr}, {31'h0, s_cur.wr});
                        check("bus_wstrb", {28'h0, wstrb}, {28'h0, s_cur.wstrb});
                        check("bus_wdata", wdata, s_cur.wdata);
                        if (s_cnt == aw_wait) begin
                            addr_ok = 1'b1;
                            s_phase = 1;
                            s_cnt   = 0;
                        end else begin
                            s_cnt++;
                        end
                    end
                end
            end else begin
                if (req) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL req_in_data: req=%b while awaiting data_ok", req);
                end
                if (s_cnt == dw_wait) begin
                    data_ok = 1'b1;
                    rdata   = s_cur.rdata;
                    s_phase = 0;
                    s_cnt   = 0;
                    s_have  = 1'b0;
                end else begin
                    s_cnt++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cyc;
        logic [31:0] old_inst;
        n_tests   = 0;
        n_fail    = 0;
        aw_wait   = 0;
        dw_wait   = 0;
        cpu_rst_n = 1'b0;
        ice = 1'b0; dce = 1'b0; flush = 1'b0;
        iaddr = '0; daddr = '0; dwe = '0; din = '0;

        vecs[0] = '{1'b1, 32'hBFC00000, 1'b0, 32'h0, 4'h0, 32'h0,
                    32'h3C08BFAF, 32'h0, 0, 0, 3, 32'h3C08BFAF, 32'h0};
        vecs[1] = '{1'b1, 32'hBFC00004, 1'b1, 32'h80001000, 4'h0, 32'h0,
                    32'h24080001, 32'h12345678, 0, 0, 6, 32'h24080001, 32'h12345678};
        vecs[2] = '{1'b0, 32'h0, 1'b1, 32'h80002000, 4'b0011, 32'hAABBCCDD,
                    32'h0, 32'hFFFF0000, 2, 0, 5, 32'h24080001, 32'h12345678};
        vecs[3] = '{1'b0, 32'h0, 1'b1, 32'h80000010, 4'h0, 32'h0,
                    32'h0, 32'hCAFEF00D, 1, 2, 6, 32'h24080001, 32'hCAFEF00D};
        vecs[4] = '{1'b1, 32'h00001000, 1'b1, 32'h00002000, 4'b1111, 32'h55667788,
                    32'h11112222, 32'h0, 1, 1, 10, 32'h11112222, 32'hCAFEF00D};

        // Reset values
        step();
        check("rst_req", {31'h0, req}, 32'h0);
        check("rst_wr", {31'h0, wr}, 32'h0);
        check("rst_wstrb", {28'h0, wstrb}, 32'h0);
        check("rst_addr", addr, 32'h0);
        check("rst_wdata", wdata, 32'h0);
        check("rst_inst", inst, 32'h0);
        check("rst_dm", dm, 32'h0);
        check("rst_stall", {31'h0, stallreq}, 32'h0);
        step();
        #1 cpu_rst_n = 1'b1;

        // Table-driven accesses; data channel is served first when both are pending
        for (int k = 0; k < 5; k++) begin
            aw_wait = vecs[k].aw;
            dw_wait = vecs[k].dw;
            if (vecs[k].dce) push_data(vecs[k].daddr, vecs[k].dwe, vecs[k].din, vecs[k].rd_d);
            if (vecs[k].ice) push_fetch(vecs[k].iaddr, vecs[k].rd_i);
            step();
            ice   = vecs[k].ice;
            iaddr = vecs[k].iaddr;
            dce   = vecs[k].dce;
            daddr = vecs[k].daddr;
            dwe   = vecs[k].dwe;
            din   = vecs[k].din;
            #2;
            wait_done(cyc);
            check($sformatf("v%0d_cycles", k), cyc, vecs[k].cycles);
            check($sformatf("v%0d_inst", k), inst, vecs[k].exp_inst);
            check($sformatf("v%0d_dm", k), dm, vecs[k].exp_dm);
            step();
            ice = 1'b0; dce = 1'b0; dwe = '0; din = '0;
            #2;
            check($sformatf("v%0d_idle_req", k), {31'h0, req}, 32'h0);
        end

        // Back-to-back fetches, each presented right after stallreq drops
        aw_wait = 0;
        dw_wait = 0;
        push_fetch(32'h0, 32'hA0000000);
        push_fetch(32'h4, 32'hA0000004);
        push_fetch(32'h8, 32'hA0000008);
        for (int k = 0; k < 3; k++) begin
            step();
            ice   = 1'b1;
            iaddr = 32'(k * 4);
            #2;
            wait_done(cyc);
            check($sformatf("b2b%0d_cycles", k), cyc, 3);
            check($sformatf("b2b%0d_inst", k), inst, 32'hA0000000 + 32'(k * 4));
        end
        step();
        ice = 1'b0;
        #2;
        check("b2b_no_dup", sb.size(), 0);

        // Flush while a fetch waits in DATA; its data_ok arrives two cycles later
        old_inst = 32'hA0000008;
        dw_wait  = 2;
        push_fetch(32'h3000, 32'hDEADBEEF);
        push_fetch(32'h4000, 32'h0BADF00D);
        step();
        ice = 1'b1; iaddr = 32'h3000;
        #2 check("fl_c0_stall", {31'h0, stallreq}, 32'h1);
        step();
        #2 check("fl_c1_req", {31'h0, req}, 32'h1);
        step();
        flush = 1'b1;
        #2 check("fl_stall_low", {31'h0, stallreq}, 32'h0);
        step();
        flush = 1'b0; iaddr = 32'h4000;
        #2 check("fl_c3_stall", {31'h0, stallreq}, 32'h1);
        check("fl_c3_req", {31'h0, req}, 32'h0);
        step();
        #2 check("fl_c4_req", {31'h0, req}, 32'h0);
        step();
        #2 check("fl_inst_kept", inst, old_inst);
        check("fl_c5_req", {31'h0, req}, 32'h0);
        step();
        #2 check("fl_refetch_req", {31'h0, req}, 32'h1);
        wait_done(cyc);
        check("fl_new_inst", inst, 32'h0BADF00D);
        step();
        ice     = 1'b0;
        dw_wait = 0;

        // Reset while in ADDR
        aw_wait = 3;
        push_fetch(32'h5000, 32'h5555AAAA);
        step();
        ice = 1'b1; iaddr = 32'h5000;
        #2;
        step();
        #2 check("ra_c1_req", {31'h0, req}, 32'h1);
        step();
        #1 cpu_rst_n = 1'b0;
        ice = 1'b0;
        #1 check("ra_req", {31'h0, req}, 32'h0);
        check("ra_inst", inst, 32'h0);
        check("ra_dm", dm, 32'h0);
        step();
        #1 cpu_rst_n = 1'b1;
        aw_wait = 0;
        push_fetch(32'h6000, 32'h600DCAFE);
        step();
        ice = 1'b1; iaddr = 32'h6000;
        #2;
        wait_done(cyc);
        check("ra_resume_cycles", cyc, 3);
        check("ra_resume_inst", inst, 32'h600DCAFE);
        check("ra_resume_dm", dm, 32'h0);
        step();
        ice = 1'b0;
        #2;
        check("sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_like_bridge.md
# sram_like_bridge

Parametrised bridge from the core's single-cycle SRAM-style instruction and data ports to one shared SRAM-like request/response bus with variable wait states. It sits between the CPU core and the memory subsystem. It serialises fetch and load/store accesses onto the bus and raises a stall request to the stall control unit until every request the core has presented this cycle has completed. One transaction is outstanding at a time; a flush discards the in-flight result without violating the bus protocol.

## Interface
- ADDR_W, 32, address width of both core ports and the bus
- DATA_W, 32, data width; must be a multiple of 8; strobe width is DATA_W/8
- DATA_FIRST, 1, when both channels are pending: 1 = data channel served first, 0 = instruction channel first
- cpu_clk_50M  in  1  clock
- cpu_rst_n  in  1  asynchronous active-low reset
- ice  in  1  fetch request, held with iaddr while stallreq=1
- iaddr  in  ADDR_W  fetch address
- inst  out  DATA_W  last fetched word, held until next fetch completes
- dce  in  1  data request, held with daddr/dwe/din while stallreq=1
- daddr  in  ADDR_W  data address
- dwe  in  DATA_W/8  byte write strobes; all zero = read
- din  in  DATA_W  store data
- dm  out  DATA_W  last load word, held until next read completes
- flush  in  1  pipeline flush (exception/eret); cancels core requests
- stallreq  out  1  core must hold its requests and not advance
- req  out  1  bus request
- wr  out  1  bus write
- wstrb  out  DATA_W/8  bus byte strobes
- addr  out  ADDR_W  bus address
- wdata  out  DATA_W  bus write data
- addr_ok  in  1  slave accepted address phase
- data_ok  in  1  slave completed transaction
- rdata  in  DATA_W  read data, valid with data_ok

## Operation
- State machine: IDLE, ADDR, DATA.
- Done flags i_done and d_done are registered. A channel is pending when its enable is high and its flag is clear. A discard flag marks a transaction whose result is dropped.
- IDLE: if any channel is pending and flush=0, select by DATA_FIRST. Latch addr/wr/wstrb/wdata and the channel id, then go to ADDR. Otherwise stay in IDLE.
- ADDR: req=1 and the latched fields are driven. On addr_ok go to DATA; otherwise hold with the fields stable.
- DATA: req=0. On data_ok:
  - if discard=0, set the selected channel's done flag and capture rdata into inst (fetch) or dm (read; writes leave dm unchanged);
  - clear discard and return to IDLE.
- stallreq = (ice & ~i_done) | (dce & ~d_done), combinational. It is forced to 0 while flush=1.
- Done flags clear at the clock edge ending any cycle with stallreq=0. The core advances in that cycle, so its next request is new.
- flush=1:
  - both done flags clear;
  - in IDLE, no transaction is started;
  - in ADDR or DATA, discard is set and the transaction runs to data_ok on the bus, with its result dropped;
  - new requests start only after returning to IDLE.
- Reset: state returns to IDLE immediately; flags, inst, dm, and latched bus fields clear. An in-flight bus transaction is abandoned; the system resets the slave together with the bridge.

## Timing
- Reset values: req=0, wr=0, wstrb=0, addr=0, wdata=0, inst=0, dm=0. stallreq follows its combinational definition from the inputs.
- Minimum single access, with addr_ok and data_ok asserted when first allowed:
  - cycle 0: request seen in IDLE;
  - cycle 1: req high;
  - cycle 2: data_ok;
  - cycle 3: stallreq=0 and result on inst/dm.
- Each added bus wait cycle adds one stall cycle.
- Fetch and data both pending, minimum case: 6 cycles to stallreq=0. The second transaction leaves IDLE the cycle after the first completes.
- A data_ok arriving in IDLE or ADDR is a slave protocol error; the bridge ignores it.
- inst and dm change only at the edge ending a cycle with a non-discarded data_ok.

## Test plan
- Fetch only: ice=1, iaddr=0xBFC00000; slave returns addr_ok in cycle 1 and data_ok with rdata=0x3C08BFAF in cycle 2 → req high in cycle 1 only, stallreq high cycles 0-2, inst=0x3C08BFAF and stallreq=0 in cycle 3.
- Simultaneous fetch and load with DATA_FIRST=1: daddr=0x80001000 completes first with dm=0x12345678, then the fetch runs → stallreq low exactly in cycle 6.
- Store: dce=1, dwe=4'b0011, din=0xAABBCCDD, with 2 addr_ok wait cycles → wr=1 and wstrb=0011 held stable for 3 req cycles; dm is unchanged afterwards.
- Flush in DATA state of a fetch, with data_ok 2 cycles later carrying 0xDEADBEEF → inst keeps its old value, stallreq=0 during flush, and the next fetch starts the cycle after data_ok.
- Back-to-back fetches to 0x0, 0x4, 0x8, each presented the cycle after stallreq drops → three distinct bus transactions and no duplicate request.
- cpu_rst_n pulled low while in ADDR → req=0 immediately, inst=dm=0, and normal access resumes after release.
